aud_src_sched: RTL and testbench
================================

AUD_SRC_SCHED -- requirements
Module: aud_src_sched

Interface
REQ-001 Parameter DATA_W, default 16, sets the sample width of both sources and of dac_data.
REQ-002 Parameter HOLD_LAST, default 1: on underrun, 1 repeats the last sample and 0 outputs zero.
REQ-003 clk_in  input  1  system clock, 50 MHz; the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scheduler run; 0 mutes and idles.
REQ-006 mode  input  2  source policy: 00 src0 only, 01 src1 only, 10 round-robin, 11 fixed priority with src0 winning.
REQ-007 lrck_in  input  1  DAC LRCK from the I2S transmitter; treated as asynchronous.
REQ-008 src0_data / src1_data  input  DATA_W  source samples.
REQ-009 src0_valid / src1_valid  input  1  sample offered.
REQ-010 src0_ready / src1_ready  output  1  sample accepted this cycle.
REQ-011 clr_stat  input  1  single-cycle clear of the underrun statistics.
REQ-012 dac_data  output  DATA_W  sample held to the transmitter data input.
REQ-013 frame_tick  output  1  one-cycle pulse per detected LRCK falling edge.
REQ-014 active_src  output  1  index of the last granted source.
REQ-015 underrun  output  1  sticky underrun flag.
REQ-016 underrun_cnt  output  8  saturating underrun count.

Function
REQ-017 lrck_in SHALL pass through a 2-flop synchronizer, then a third register for edge detection; a 1->0 transition SHALL assert frame_tick for exactly one clk_in cycle.
REQ-018 The FSM SHALL have three states: IDLE, WAIT_FRAME and SELECT.
REQ-019 IDLE: on enable=1, go to WAIT_FRAME.
REQ-020 WAIT_FRAME: on frame_tick, go to SELECT.
REQ-021 SELECT lasts exactly one cycle and always returns to WAIT_FRAME.
REQ-022 From any state, enable=0 SHALL force IDLE on the next edge.
REQ-023 Entering IDLE SHALL zero dac_data and hold both ready outputs low.
REQ-024 Only in SELECT, the eligible valid source is granted: its ready is 1 for that single cycle, and its data loads into dac_data on the same edge.
REQ-025 Latency: dac_data SHALL update exactly 5 clk_in edges after the lrck_in falling edge (2 synchronizer edges, 1 detect edge, 1 FSM edge, 1 load edge).
REQ-026 Eligibility: in mode 00 only src0 is eligible, and in mode 01 only src1; src1_valid or src0_valid respectively SHALL be ignored, with ready held 0.
REQ-027 Mode 10: if both sources are valid, grant the source not equal to active_src; otherwise grant whichever source is valid.
REQ-028 Mode 11: src0 wins whenever it is valid.
REQ-029 active_src SHALL update only on a grant.
REQ-030 Underrun (SELECT with no eligible valid source): set underrun, increment underrun_cnt saturating at 255, and either hold dac_data (HOLD_LAST=1) or zero it (HOLD_LAST=0).
REQ-031 clr_stat SHALL zero underrun and underrun_cnt on the next edge.
REQ-032 If clr_stat coincides with an underrun, the result SHALL be underrun=1 and underrun_cnt=1.
REQ-033 A frame_tick arriving in IDLE or SELECT SHALL be ignored.
REQ-034 Mode changes SHALL take effect at the next SELECT.
REQ-035 No grant ever occurs outside SELECT.

Reset
REQ-036 With rst_n low, asynchronously: FSM=IDLE, all synchronizer/edge registers=0, dac_data=0, ready outputs=0, frame_tick=0, active_src=1 (so src0 wins first round-robin tie), underrun=0, underrun_cnt=0.
REQ-037 A reset asserted mid-SELECT SHALL suppress that cycle's grant, with no sample consumed.

Structure
REQ-038 The shared audio package SHALL hold the mode encodings, the FSM state type and the DATA_W default.
REQ-039 The synchronizer plus falling-edge detector SHALL be one sub-module, aud_edge_sync, reusable for the BCLK/LRCK domains.
REQ-040 The arbiter SHALL remain inline.

Verification
REQ-041 Mode 11, both valid, data 0x1234/0xABCD, one lrck_in fall -> src0_ready pulses once and dac_data=0x1234 at edge +5.
REQ-042 Mode 10, both valid, 4 frames -> grants src0, src1, src0, src1; active_src toggles each frame.
REQ-043 Mode 00, src0_valid=0, src1_valid=1, HOLD_LAST=1, previous sample 0x0F0F -> dac_data stays 0x0F0F, underrun=1, cnt=1, src1_ready never asserts.
REQ-044 300 consecutive underrun frames -> underrun_cnt saturates at 255; clr_stat plus a simultaneous underrun -> cnt=1.
REQ-045 enable dropped between frame_tick and SELECT -> no ready pulse and dac_data=0.
REQ-046 rst_n pulsed low during SELECT -> outputs return to reset values and the source's valid data is not consumed.

Source files
------------

// File: rtl/aud_src_sched_pkg.sv
// Shared audio package: source-policy encodings, scheduler FSM state type,
// the default sample width and a saturating counter helper.
package aud_src_sched_pkg;

  localparam int AUD_DATA_W = 16;

  // Source policy driven on the mode input.
  typedef enum logic [1:0] {
    MODE_SRC0 = 2'b00,   // src0 only
    MODE_SRC1 = 2'b01,   // src1 only
    MODE_RR   = 2'b10,   // round-robin between the two sources
    MODE_PRIO = 2'b11    // fixed priority, src0 wins
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SELECT     = 2'd2
  } state_e;

  localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

  // Increment that sticks at UNDERRUN_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == UNDERRUN_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/aud_src_sched_if.sv
// Two-source sample handshake bundle between audio sources and the scheduler.
//   src0_data/src1_data   : offered samples
//   src0_valid/src1_valid : sample offered
//   src0_ready/src1_ready : sample accepted this cycle
// master = source side, slave = scheduler side.
interface aud_src_sched_if
  import aud_src_sched_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W
);
  logic [DATA_W-1:0] src0_data;
  logic [DATA_W-1:0] src1_data;
  logic              src0_valid;
  logic              src1_valid;
  logic              src0_ready;
  logic              src1_ready;

  modport master (
    output src0_data, src1_data, src0_valid, src1_valid,
    input  src0_ready, src1_ready
  );

  modport slave (
    input  src0_data, src1_data, src0_valid, src1_valid,
    output src0_ready, src1_ready
  );
endinterface

// File: rtl/aud_edge_sync.sv
// Two-flop synchronizer for an asynchronous serial-audio clock (LRCK/BCLK)
// followed by a falling-edge detector.
//   clk_in  : system clock
//   rst_n   : asynchronous active-low reset
//   async_i : asynchronous input
//   fall_o  : registered one-cycle pulse per detected 1->0 transition
// A fall before edge 1 reaches sync_q after edge 2 and fall_o after edge 3.
module aud_edge_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_i,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic last_q;
  logic fall_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbour; blocking here would collapse
  // the synchronizer chain into a single flop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      last_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      last_q <= sync_q;
      fall_q <= last_q & ~sync_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/aud_src_sched.sv
// Audio source scheduler: once per LRCK frame, picks one of two sample
// sources according to mode and loads its sample into the DAC data register.
//   clk_in       : 50 MHz system clock
//   rst_n        : asynchronous active-low reset
//   enable       : run; low mutes (dac_data=0) and idles
//   mode         : source policy (see mode_e)
//   lrck_in      : asynchronous DAC LRCK
//   clr_stat     : single-cycle clear of underrun statistics
//   src_if       : two-source valid/ready sample handshake
//   dac_data     : held sample to the transmitter
//   frame_tick   : one-cycle pulse per LRCK falling edge
//   active_src   : index of the last granted source
//   underrun     : sticky underrun flag
//   underrun_cnt : saturating underrun count
module aud_src_sched
  import aud_src_sched_pkg::*;
#(
  parameter int DATA_W    = AUD_DATA_W,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              lrck_in,
  input  logic              clr_stat,
  aud_src_sched_if.slave    src_if,
  output logic [DATA_W-1:0] dac_data,
  output logic              frame_tick,
  output logic              active_src,
  output logic              underrun,
  output logic [7:0]        underrun_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              active_q, active_d;
  logic              under_q, under_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_base;

  mode_e mode_s;
  logic  elig0, elig1;
  logic  gnt_any, gnt_idx;
  logic  sel_live;

  aud_edge_sync u_lrck_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .async_i(lrck_in),
    .fall_o (frame_tick)
  );

  assign mode_s = mode_e'(mode);

  // Inline arbiter. A source outside the current policy is never eligible,
  // so its valid is ignored and its ready stays low.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    elig0   = src_if.src0_valid && (mode_s != MODE_SRC1);
    elig1   = src_if.src1_valid && (mode_s != MODE_SRC0);
    gnt_any = elig0 || elig1;
    gnt_idx = elig0 ? 1'b0 : 1'b1;
    if (mode_s == MODE_RR && elig0 && elig1) begin
      gnt_idx = ~active_q;
    end
  end

  // Grants are confined to the single SELECT cycle; dropping enable in that
  // cycle mutes instead of consuming a sample.
  assign sel_live          = (state_q == ST_SELECT) && enable;
  assign src_if.src0_ready = sel_live && gnt_any && !gnt_idx;
  assign src_if.src1_ready = sel_live && gnt_any &&  gnt_idx;

  // FSM state register.
  // NOTE: every register, including the sample register, is cleared by the
  // async reset so outputs are defined before the first frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state. Ticks seen in IDLE or SELECT are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       state_d = ST_WAIT_FRAME;
      ST_WAIT_FRAME: if (frame_tick) state_d = ST_SELECT;
      ST_SELECT:     state_d = ST_WAIT_FRAME;
      default:       state_d = ST_IDLE;
    endcase
    if (!enable) state_d = ST_IDLE;
  end

  // Datapath next state. clr_stat is applied first so a coincident underrun
  // lands on top of the cleared values (flag=1, count=1).
  always_comb begin
    dac_d    = dac_q;
    active_d = active_q;
    cnt_base = clr_stat ? 8'd0 : cnt_q;
    under_d  = clr_stat ? 1'b0 : under_q;
    cnt_d    = cnt_base;
    if (!enable) begin
      dac_d = '0;
    end else if (sel_live) begin
      if (gnt_any) begin
        dac_d    = gnt_idx ? src_if.src1_data : src_if.src0_data;
        active_d = gnt_idx;
      end else begin
        under_d = 1'b1;
        cnt_d   = sat_inc8(cnt_base);
        if (!HOLD_LAST) dac_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dac_q    <= '0;
      active_q <= 1'b1;  // src0 wins the first round-robin tie
      under_q  <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      dac_q    <= dac_d;
      active_q <= active_d;
      under_q  <= under_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dac_data     = dac_q;
  assign active_src   = active_q;
  assign underrun     = under_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_aud_src_sched.sv
module tb_aud_src_sched;

  localparam int DW = 16;

  logic          clk_in   = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic [1:0]    mode     = 2'b00;
  logic          lrck_in  = 1'b1;
  logic          clr_stat = 1'b0;
  logic [DW-1:0] dac_data;
  logic          frame_tick;
  logic          active_src;
  logic          underrun;
  logic [7:0]    underrun_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: what the DAC should hold after each frame.
  logic [DW-1:0] m_dac;
  int            m_last;
  logic          m_under;
  int            m_cnt;

  aud_src_sched_if #(.DATA_W(DW)) src_if ();

  always #10 clk_in = ~clk_in;

  aud_src_sched #(.DATA_W(DW), .HOLD_LAST(1'b1)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .lrck_in     (lrck_in),
    .clr_stat    (clr_stat),
    .src_if      (src_if.slave),
    .dac_data    (dac_data),
    .frame_tick  (frame_tick),
    .active_src  (active_src),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Which source a frame should grant: -1 means underrun.
  function automatic int ref_pick(input logic [1:0] md, input logic v0, input logic v1,
                                  input int last);
    case (md)
      2'b00:   return v0 ? 0 : -1;
      2'b01:   return v1 ? 1 : -1;
      2'b10:   return (v0 && v1) ? (1 - last) : (v0 ? 0 : (v1 ? 1 : -1));
      default: return v0 ? 0 : (v1 ? 1 : -1);
    endcase
  endfunction

  function automatic int model_frame(input logic [1:0] md, input logic v0, input logic v1,
                                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int g;
    g = ref_pick(md, v0, v1, m_last);
    if (g == 0) begin
      m_dac = d0; m_last = 0;
    end else if (g == 1) begin
      m_dac = d1; m_last = 1;
    end else begin
      m_under = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; lrck_in = 1'b1; clr_stat = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    m_dac = '0; m_last = 1; m_under = 1'b0; m_cnt = 0;
  endtask

  // One LRCK fall. Samples every negedge k after posedge k (edge 1 is the
  // first posedge after the fall). clr_at/drop_at act right after sample k.
  task automatic run_frame(input int clr_at, input int drop_at,
                           output int n0, output int n1, output int nt, output int sel_at,
                           output logic [DW-1:0] dac4, output logic [DW-1:0] dac5);
    n0 = 0; n1 = 0; nt = 0; sel_at = 0; dac4 = '0; dac5 = '0;
    @(negedge clk_in);
    lrck_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_in);
      if (src_if.src0_ready) begin n0++; sel_at = k; end
      if (src_if.src1_ready) begin n1++; sel_at = k; end
      if (frame_tick) nt++;
      if (k == 4) dac4 = dac_data;
      if (k == 5) dac5 = dac_data;
      clr_stat = (k == clr_at);
      if (k == drop_at) enable = 1'b0;
    end
    clr_stat = 1'b0;
    lrck_in  = 1'b1;
    repeat (4) @(negedge clk_in);
  endtask

  task automatic test_reset();
    enable = 1'b0;
    do_reset();
    total++; if (dac_data !== 16'h0) begin bad++; $display("FAIL reset_dac got=%h exp=0", dac_data); end
    total++; if (src_if.src0_ready !== 1'b0 || src_if.src1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", src_if.src0_ready, src_if.src1_ready); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    total++; if (active_src !== 1'b1) begin bad++; $display("FAIL reset_active got=%b exp=1", active_src); end
    total++; if (underrun !== 1'b0 || underrun_cnt !== 8'd0) begin bad++; $display("FAIL reset_stat got=%b/%0d exp=0/0", underrun, underrun_cnt); end
  endtask

  task automatic test_priority();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5;
    enable = 1'b1; mode = 2'b11;
    src_if.src0_valid = 1'b1; src_if.src1_valid = 1'b1;
    src_if.src0_data = 16'h1234; src_if.src1_data = 16'hABCD;
    repeat (2) @(negedge clk_in);
    run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
    g = model_frame(2'b11, 1'b1, 1'b1, 16'h1234, 16'hABCD);
    total++; if (n0 !== 1 || n1 !== 0) begin bad++; $display("FAIL prio_ready got=%0d/%0d exp=1/0", n0, n1); end
    total++; if (nt !== 1) begin bad++; $display("FAIL prio_tick_count got=%0d exp=1", nt); end
    total++; if (sel_at !== 4) begin bad++; $display("FAIL prio_ready_edge got=%0d exp=4", sel_at); end
    total++; if (d4 !== 16'h0) begin bad++; $display("FAIL prio_dac_edge4 got=%h exp=0", d4); end
    total++; if (d5 !== 16'h1234) begin bad++; $display("FAIL prio_dac_edge5 got=%h exp=1234", d5); end
    total++; if (active_src !== g[0]) begin bad++; $display("FAIL prio_active got=%b exp=%b", active_src, g[0]); end
  endtask

  task automatic test_round_robin();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5, a, b;
    do_reset();
    enable = 1'b1; mode = 2'b10;
    src_if.src0_valid = 1'b1; src_if.src1_valid = 1'b1;
    repeat (2) @(negedge clk_in);
    for (int f = 0; f < 4; f++) begin
      a = DW'($urandom); b = DW'($urandom);
      src_if.src0_data = a; src_if.src1_data = b;
      run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
      g = model_frame(2'b10, 1'b1, 1'b1, a, b);
      total++; if (g !== f % 2) begin bad++; $display("FAIL rr_model_order frame=%0d got=%0d exp=%0d", f, g, f % 2); end
      total++; if (n0 !== (f % 2 == 0 ? 1 : 0) || n1 !== (f % 2 == 1 ? 1 : 0)) begin bad++; $display("FAIL rr_ready frame=%0d got=%0d/%0d", f, n0, n1); end
      total++; if (active_src !== 1'(f % 2)) begin bad++; $display("FAIL rr_active frame=%0d got=%b exp=%0d", f, active_src, f % 2); end
      total++; if (d5 !== m_dac) begin bad++; $display("FAIL rr_dac frame=%0d got=%h exp=%h", f, d5, m_dac); end
    end
  endtask

  task automatic test_underrun_hold();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5;
    do_reset();
    enable = 1'b1; mode = 2'b00;
    src_if.src0_valid = 1'b1; src_if.src1_valid = 1'b0;
    src_if.src0_data = 16'h0F0F; src_if.src1_data = 16'h5555;
    repeat (2) @(negedge clk_in);
    run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
    g = model_frame(2'b00, 1'b1, 1'b0, 16'h0F0F, 16'h5555);
    total++; if (d5 !== 16'h0F0F) begin bad++; $display("FAIL hold_load got=%h exp=0f0f", d5); end
    src_if.src0_valid = 1'b0; src_if.src1_valid = 1'b1;
    run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
    g = model_frame(2'b00, 1'b0, 1'b1, 16'h0F0F, 16'h5555);
    total++; if (n0 !== 0 || n1 !== 0) begin bad++; $display("FAIL hold_ready got=%0d/%0d exp=0/0", n0, n1); end
    total++; if (dac_data !== 16'h0F0F) begin bad++; $display("FAIL hold_dac got=%h exp=0f0f", dac_data); end
    total++; if (underrun !== 1'b1 || underrun_cnt !== 8'd1) begin bad++; $display("FAIL hold_stat got=%b/%0d exp=1/1", underrun, underrun_cnt); end
  endtask

  task automatic test_saturate();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5;
    for (int f = 0; f < 299; f++) begin
      run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
      g = model_frame(2'b00, 1'b0, 1'b1, 16'h0F0F, 16'h5555);
    end
    total++; if (underrun_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL sat_cnt got=%0d exp=%0d", underrun_cnt, m_cnt); end
    total++; if (underrun_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt_max got=%0d exp=255", underrun_cnt); end
    run_frame(4, 0, n0, n1, nt, sel_at, d4, d5);
    m_cnt = 1; m_under = 1'b1;
    total++; if (underrun !== 1'b1 || underrun_cnt !== 8'd1) begin bad++; $display("FAIL clr_with_underrun got=%b/%0d exp=1/1", underrun, underrun_cnt); end
    @(negedge clk_in); clr_stat = 1'b1;
    @(negedge clk_in); clr_stat = 1'b0;
    m_cnt = 0; m_under = 1'b0;
    total++; if (underrun !== 1'b0 || underrun_cnt !== 8'd0) begin bad++; $display("FAIL clr_plain got=%b/%0d exp=0/0", underrun, underrun_cnt); end
  endtask

  task automatic test_enable_drop();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5;
    mode = 2'b11;
    src_if.src0_valid = 1'b1; src_if.src0_data = 16'h7777;
    run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
    g = model_frame(2'b11, 1'b1, 1'b1, 16'h7777, 16'h5555);
    total++; if (d5 !== 16'h7777) begin bad++; $display("FAIL drop_preload got=%h exp=7777", d5); end
    src_if.src0_data = 16'h8888;
    run_frame(0, 3, n0, n1, nt, sel_at, d4, d5);
    m_dac = '0;
    total++; if (n0 + n1 !== 0) begin bad++; $display("FAIL drop_ready got=%0d exp=0", n0 + n1); end
    total++; if (nt !== 1) begin bad++; $display("FAIL drop_tick got=%0d exp=1", nt); end
    total++; if (d5 !== 16'h0 || dac_data !== 16'h0) begin bad++; $display("FAIL drop_dac got=%h/%h exp=0", d5, dac_data); end
    total++; if (active_src !== 1'b0) begin bad++; $display("FAIL drop_active got=%b exp=0", active_src); end
    enable = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_reset_in_select();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5;
    mode = 2'b11;
    src_if.src0_valid = 1'b1; src_if.src1_valid = 1'b0; src_if.src0_data = 16'h3131;
    run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
    g = model_frame(2'b11, 1'b1, 1'b0, 16'h3131, 16'h5555);
    total++; if (dac_data !== 16'h3131 || active_src !== 1'b0) begin bad++; $display("FAIL rsel_preload got=%h/%b exp=3131/0", dac_data, active_src); end
    src_if.src0_data = 16'h4242;
    @(negedge clk_in); lrck_in = 1'b0;
    repeat (4) @(negedge clk_in);
    total++; if (src_if.src0_ready !== 1'b1) begin bad++; $display("FAIL rsel_in_select got=%b exp=1", src_if.src0_ready); end
    rst_n = 1'b0;
    #1;
    total++; if (src_if.src0_ready !== 1'b0) begin bad++; $display("FAIL rsel_ready_async got=%b exp=0", src_if.src0_ready); end
    @(posedge clk_in); #1;
    total++; if (dac_data !== 16'h0) begin bad++; $display("FAIL rsel_dac got=%h exp=0", dac_data); end
    total++; if (active_src !== 1'b1 || frame_tick !== 1'b0) begin bad++; $display("FAIL rsel_active_tick got=%b/%b exp=1/0", active_src, frame_tick); end
    total++; if (src_if.src0_ready !== 1'b0 || src_if.src1_ready !== 1'b0) begin bad++; $display("FAIL rsel_consumed got=%b%b exp=00", src_if.src0_ready, src_if.src1_ready); end
    @(negedge clk_in);
    rst_n = 1'b1; lrck_in = 1'b1;
    repeat (4) @(negedge clk_in);
    m_dac = '0; m_last = 1; m_under = 1'b0; m_cnt = 0;
    total++; if (dac_data !== 16'h0 || underrun_cnt !== 8'd0) begin bad++; $display("FAIL rsel_after got=%h/%0d exp=0/0", dac_data, underrun_cnt); end
  endtask

  task automatic test_random();
    int n0, n1, nt, sel_at, g;
    logic [DW-1:0] d4, d5, a, b;
    logic [1:0] md;
    logic v0, v1;
    enable = 1'b1;
    repeat (2) @(negedge clk_in);
    for (int f = 0; f < 40; f++) begin
      md = 2'($urandom_range(0, 3));
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a = DW'($urandom); b = DW'($urandom);
      mode = md;
      src_if.src0_valid = v0; src_if.src1_valid = v1;
      src_if.src0_data = a; src_if.src1_data = b;
      run_frame(0, 0, n0, n1, nt, sel_at, d4, d5);
      g = model_frame(md, v0, v1, a, b);
      total++; if (n0 !== (g == 0 ? 1 : 0) || n1 !== (g == 1 ? 1 : 0)) begin bad++; $display("FAIL rnd_ready frame=%0d mode=%b v=%b%b got=%0d/%0d exp_src=%0d", f, md, v0, v1, n0, n1, g); end
      total++; if (d5 !== m_dac) begin bad++; $display("FAIL rnd_dac frame=%0d got=%h exp=%h", f, d5, m_dac); end
      total++; if (active_src !== 1'(m_last)) begin bad++; $display("FAIL rnd_active frame=%0d got=%b exp=%0d", f, active_src, m_last); end
      total++; if (underrun !== m_under || underrun_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_stat frame=%0d got=%b/%0d exp=%b/%0d", f, underrun, underrun_cnt, m_under, m_cnt); end
      if (g >= 0) begin
        total++; if (sel_at !== 4) begin bad++; $display("FAIL rnd_grant_edge frame=%0d got=%0d exp=4", f, sel_at); end
      end
    end
  endtask

  initial begin
    src_if.src0_valid = 1'b0; src_if.src1_valid = 1'b0;
    src_if.src0_data = '0; src_if.src1_data = '0;
    m_dac = '0; m_last = 1; m_under = 1'b0; m_cnt = 0;
    test_reset();
    test_priority();
    test_round_robin();
    test_underrun_hold();
    test_saturate();
    test_enable_drop();
    test_reset_in_select();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
